// File: rtl/bandit_pkg.sv
// Shared types and defaults for the slot-machine front-end.
// Holds the per-channel debounce FSM state encoding and the default
// timing constants used by button_conditioner and debounce_channel.
package bandit_pkg;

    // Per-channel debounce FSM states (2-bit encoding).
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } deb_state_e;

    // 20 ms at 50 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    // 0.5 s at 50 MHz; only meaningful with BUTTON_AUTOREPEAT_EN.
    localparam int DEFAULT_REPEAT_CYCLES   = 25000000;

endpackage

// File: rtl/button_conditioner_debounce.sv
// debounce_channel: one button channel.
// Synchronises a raw asynchronous level through a SYNC_STAGES flop chain,
// then runs a four-state debounce FSM that registers a one-cycle pulse per
// accepted press and the debounced level.
// Optional feature (macro BUTTON_AUTOREPEAT_EN): while the button stays in
// PRESSED, an extra pulse is emitted every REPEAT_CYCLES cycles.
module debounce_channel
    import bandit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic pulse_o,
    output logic lvl_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time guards on the legal parameter ranges.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("debounce_channel: DEBOUNCE_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_channel: SYNC_STAGES must be >= 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("debounce_channel: REPEAT_CYCLES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    deb_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   pulse_q;
    logic                   lvl_q;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0] rpt_q;
`endif

    // Shift the raw level through the synchroniser chain; MSB is the safe copy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Debounce FSM with registered pulse/level outputs; counter only advances
    // while the synchronised level disagrees with the accepted level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            lvl_q   <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sync) begin
                        state_q <= ST_PRESS_CHK;
                        cnt_q   <= '0;
                    end
                end
                ST_PRESS_CHK: begin
                    if (!sync) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= ST_PRESSED;
                        pulse_q <= 1'b1;
                        lvl_q   <= 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
                        rpt_q   <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!sync) begin
                        state_q <= ST_RELEASE_CHK;
                        cnt_q   <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
                        rpt_q   <= '0;
                    end else if (rpt_q == RPT_MAX) begin
                        pulse_q <= 1'b1;
                        rpt_q   <= '0;
                    end else begin
                        rpt_q <= rpt_q + RPT_W'(1);
`endif
                    end
                end
                ST_RELEASE_CHK: begin
                    if (sync) begin
                        // Release bounce: back to PRESSED, no new pulse.
                        state_q <= ST_PRESSED;
`ifdef BUTTON_AUTOREPEAT_EN
                        rpt_q   <= '0;
`endif
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= ST_IDLE;
                        lvl_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pulse_o = pulse_q;
    assign lvl_o   = lvl_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: conditions the raw start and coin push-buttons for the
// slot-machine Control FSM. Two identical, independent debounce channels;
// both pulses may assert in the same cycle.
// Optional feature (macro BUTTON_AUTOREPEAT_EN): held buttons auto-repeat
// their pulse every REPEAT_CYCLES cycles. Port list is the same either way.
module button_conditioner
    import bandit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic start_btn,
    input  logic coin_btn,
    output logic start_p,
    output logic coin_p,
    output logic start_lvl,
    output logic coin_lvl
);

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_start (
        .clk_i   (clk),
        .rst_i   (rst),
        .raw_i   (start_btn),
        .pulse_o (start_p),
        .lvl_o   (start_lvl)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_coin (
        .clk_i   (clk),
        .rst_i   (rst),
        .raw_i   (coin_btn),
        .pulse_o (coin_p),
        .lvl_o   (coin_lvl)
    );

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// SYNC_STAGES=2, REPEAT_CYCLES=8. Edge numbers in comments count from the
// first edge at which a new raw value is sampled; with these parameters a
// stable press is accepted at edge 2+4+1 = 7.
module tb_button_conditioner;

    localparam int DEB = 4;
    localparam int SYN = 2;
    localparam int RPT = 8;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start_btn;
    logic coin_btn;
    logic start_p;
    logic coin_p;
    logic start_lvl;
    logic coin_lvl;

    int checks   = 0;
    int failures = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYN),
        .REPEAT_CYCLES   (RPT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_btn (start_btn),
        .coin_btn  (coin_btn),
        .start_p   (start_p),
        .coin_p    (coin_p),
        .start_lvl (start_lvl),
        .coin_lvl  (coin_lvl)
    );

    // Clock
    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input string sig, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s %s observed=%b expected=%b", tag, sig, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, take the edge, check all outputs #1 later
    task automatic cyc(input logic r, input logic s, input logic c,
                       input logic e_sp, input logic e_cp,
                       input logic e_sl, input logic e_cl,
                       input string tag);
        rst       = r;
        start_btn = s;
        coin_btn  = c;
        @(posedge clk);
        #1;
        chk(tag, "start_p",   start_p,   e_sp);
        chk(tag, "coin_p",    coin_p,    e_cp);
        chk(tag, "start_lvl", start_lvl, e_sl);
        chk(tag, "coin_lvl",  coin_lvl,  e_cl);
    endtask

    initial begin
        rst       = 1'b1;
        start_btn = 1'b0;
        coin_btn  = 1'b0;

        // Reset state
        for (int e = 1; e <= 2; e++) cyc(1, 0, 0, 0, 0, 0, 0, "reset");
        for (int e = 1; e <= 3; e++) cyc(0, 0, 0, 0, 0, 0, 0, "idle");

        // Clean press: start held 20 edges -> pulse at 7 (and 15 with autorepeat)
        for (int e = 1; e <= 20; e++)
            cyc(0, 1, 0, (e == 7) || (AR && e == 15), 0, e >= 7, 0, "clean_press");
        // Clean release: lvl falls at edge 7 after raw first sampled low
        for (int e = 1; e <= 10; e++)
            cyc(0, 0, 0, 0, 0, e < 7, 0, "clean_release");

        // Coin bounce: high 2, low 1, high 2, low -> nothing
        for (int e = 1; e <= 12; e++)
            cyc(0, 0, (e <= 2) || (e == 4) || (e == 5), 0, 0, 0, 0, "coin_bounce");
        // Coin clean press of 10 edges -> single pulse at 7
        for (int e = 1; e <= 10; e++)
            cyc(0, 0, 1, 0, e == 7, 0, e >= 7, "coin_press");
        for (int e = 1; e <= 10; e++)
            cyc(0, 0, 0, 0, 0, 0, e < 7, "coin_release");

        // Release bounce: accepted press, low 2, high again -> lvl held, no pulse
        for (int e = 1; e <= 10; e++)
            cyc(0, 1, 0, e == 7, 0, e >= 7, 0, "rb_press");
        for (int e = 1; e <= 10; e++)
            cyc(0, e > 2, 0, 0, 0, 1, 0, "rb_bounce");
        for (int e = 1; e <= 10; e++)
            cyc(0, 0, 0, 0, 0, e < 7, 0, "rb_release");

        // Simultaneous press: both pulse at edge 7 in the same cycle
        for (int e = 1; e <= 10; e++)
            cyc(0, 1, 1, e == 7, e == 7, e >= 7, e >= 7, "simul_press");
        for (int e = 1; e <= 10; e++)
            cyc(0, 0, 0, 0, 0, e < 7, e < 7, "simul_release");

        // Reset mid-press: rst sampled at edges 5 and 6, button held -> pulse at 13
        for (int e = 1; e <= 4; e++)
            cyc(0, 1, 0, 0, 0, 0, 0, "rst_mid_pre");
        for (int e = 5; e <= 6; e++)
            cyc(1, 1, 0, 0, 0, 0, 0, "rst_mid_rst");
        for (int e = 7; e <= 18; e++)
            cyc(0, 1, 0, e == 13, 0, e >= 13, 0, "rst_mid_post");
        for (int e = 1; e <= 10; e++)
            cyc(0, 0, 0, 0, 0, e < 7, 0, "rst_mid_release");

        // Coin held 30 edges: pulses at 7 (+15, 23, 31 with autorepeat)
        for (int e = 1; e <= 30; e++)
            cyc(0, 0, 1, 0, (e == 7) || (AR && (e == 15 || e == 23)), 0, e >= 7, "coin_hold");
        for (int e = 31; e <= 40; e++)
            cyc(0, 0, 0, 0, AR && e == 31, 0, e < 37, "coin_hold_release");

        // Final quiet period
        for (int e = 1; e <= 4; e++) cyc(0, 0, 0, 0, 0, 0, 0, "quiet");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
